// File: rtl/fu_pkg.sv
// Shared opcode, state and width definitions for the functional-unit shell,
// scoreboard and register file.
`default_nettype none
`timescale 1ns/1ps

package fu_pkg;

  localparam int FU_DATA_W = 32;
  localparam int FU_REG_AW = 5;
  localparam int FU_OP_W   = 4;
  localparam int FU_CNT_W  = 4;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_SLL = 5;
  localparam int OP_SRL = 6;
  localparam int OP_MUL = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_EXEC     = 2'd2,
    ST_WAIT_WB  = 2'd3
  } fu_state_e;

endpackage

`default_nettype wire

// File: rtl/fu_exec_unit_if.sv
// Scoreboard / register-file handshake bundle for one functional unit.
`default_nettype none
`timescale 1ns/1ps

interface fu_exec_unit_if
  import fu_pkg::*;
#(
  parameter int DATA_W = FU_DATA_W,
  parameter int REG_AW = FU_REG_AW,
  parameter int OP_W   = FU_OP_W
);

  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [REG_AW-1:0] issue_fi;
  logic [REG_AW-1:0] issue_fj;
  logic [REG_AW-1:0] issue_fk;
  logic              busy;
  logic [REG_AW-1:0] dest_reg;
  logic [REG_AW-1:0] rd_j_addr;
  logic [REG_AW-1:0] rd_k_addr;
  logic              read_grant;
  logic [DATA_W-1:0] src_j_data;
  logic [DATA_W-1:0] src_k_data;
  logic              wb_req;
  logic              wb_grant;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              issue_err;

  modport master (
    output issue_valid, issue_op, issue_fi, issue_fj, issue_fk,
    output read_grant, src_j_data, src_k_data, wb_grant, flush,
    input  busy, dest_reg, rd_j_addr, rd_k_addr,
    input  wb_req, wb_en, wb_addr, wb_data, issue_err
  );

  modport slave (
    input  issue_valid, issue_op, issue_fi, issue_fj, issue_fk,
    input  read_grant, src_j_data, src_k_data, wb_grant, flush,
    output busy, dest_reg, rd_j_addr, rd_k_addr,
    output wb_req, wb_en, wb_addr, wb_data, issue_err
  );

endinterface

`default_nettype wire

// File: rtl/fu_alu.sv
// Integer datapath for the FU shell; opcodes outside ADD..MUL yield zero.
`default_nettype none
`timescale 1ns/1ps

module fu_alu
  import fu_pkg::*;
#(
  parameter int DATA_W = FU_DATA_W,
  parameter int OP_W   = FU_OP_W
) (
  input  wire [OP_W-1:0]   op_i,
  input  wire [DATA_W-1:0] a_i,
  input  wire [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_W'(OP_ADD): result_o = a_i + b_i;
      OP_W'(OP_SUB): result_o = a_i - b_i;
      OP_W'(OP_AND): result_o = a_i & b_i;
      OP_W'(OP_OR):  result_o = a_i | b_i;
      OP_W'(OP_XOR): result_o = a_i ^ b_i;
      OP_W'(OP_SLL): result_o = a_i << shamt;
      OP_W'(OP_SRL): result_o = a_i >> shamt;
      OP_W'(OP_MUL): result_o = a_i * b_i;
      default:       result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fu_exec_unit.sv
// +------------------------------------------------------------------+
// | fu_exec_unit : multi-cycle FU shell between scoreboard and RF    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module fu_exec_unit
  import fu_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DATA_W  = FU_DATA_W,
  parameter int REG_AW  = FU_REG_AW,
  parameter int OP_W    = FU_OP_W
) (
  input wire            clk,
  input wire            rst,
  fu_exec_unit_if.slave bus
);

  localparam logic [FU_CNT_W-1:0] C_CNT_LOAD = FU_CNT_W'(LATENCY - 1);
  localparam bit                  C_SINGLE   = (LATENCY == 1);

  fu_state_e               state_q;
  logic [OP_W-1:0]         op_q;
  logic [REG_AW-1:0]       dest_q;
  logic [REG_AW-1:0]       fj_q;
  logic [REG_AW-1:0]       fk_q;
  logic [DATA_W-1:0]       opa_q;
  logic [DATA_W-1:0]       opb_q;
  logic [FU_CNT_W-1:0]     cnt_q;
  logic                    busy_q;
  logic                    wb_req_q;
  logic [DATA_W-1:0]       wb_data_q;
  logic                    err_q;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [DATA_W-1:0]       result_d;

  // A single-cycle build computes straight from the read ports at the grant edge.
  assign alu_a = (state_q == ST_WAIT_OPS) ? bus.src_j_data : opa_q;
  assign alu_b = (state_q == ST_WAIT_OPS) ? bus.src_k_data : opb_q;

  fu_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op_i     (op_q),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (result_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      fj_q      <= '0;
      fk_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      wb_req_q  <= 1'b0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (bus.issue_valid && (state_q != ST_IDLE)) begin
        err_q <= 1'b1;
      end
      if (bus.flush) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        wb_req_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.issue_valid) begin
              op_q    <= bus.issue_op;
              dest_q  <= bus.issue_fi;
              fj_q    <= bus.issue_fj;
              fk_q    <= bus.issue_fk;
              busy_q  <= 1'b1;
              state_q <= ST_WAIT_OPS;
            end
          end
          ST_WAIT_OPS: begin
            if (bus.read_grant) begin
              opa_q <= bus.src_j_data;
              opb_q <= bus.src_k_data;
              cnt_q <= C_CNT_LOAD;
              if (C_SINGLE) begin
                wb_data_q <= result_d;
                wb_req_q  <= 1'b1;
                state_q   <= ST_WAIT_WB;
              end else begin
                state_q <= ST_EXEC;
              end
            end
          end
          ST_EXEC: begin
            if (cnt_q == '0) begin
              wb_data_q <= result_d;
              wb_req_q  <= 1'b1;
              state_q   <= ST_WAIT_WB;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_WAIT_WB: begin
            if (bus.wb_grant) begin
              wb_req_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
          default: begin
            busy_q   <= 1'b0;
            wb_req_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.dest_reg  = dest_q;
  assign bus.rd_j_addr = fj_q;
  assign bus.rd_k_addr = fk_q;
  assign bus.wb_req    = wb_req_q;
  assign bus.wb_en     = wb_req_q & bus.wb_grant & ~bus.flush;
  assign bus.wb_addr   = dest_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.issue_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fu_exec_unit.sv
// Scoreboard bench for fu_exec_unit: a LATENCY=4 unit and a LATENCY=1 unit.
`default_nettype none
`timescale 1ns/1ps

module tb_fu_exec_unit;
  import fu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_exec_unit_if #(.DATA_W(32), .REG_AW(5), .OP_W(4)) bus_a ();
  fu_exec_unit_if #(.DATA_W(32), .REG_AW(5), .OP_W(4)) bus_b ();

  fu_exec_unit #(.LATENCY(4), .DATA_W(32), .REG_AW(5), .OP_W(4)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  fu_exec_unit #(.LATENCY(1), .DATA_W(32), .REG_AW(5), .OP_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t qa[$];
  wb_t qb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write-back monitors: every wb_en must match the oldest expected write.
  wb_t exp_a;
  always @(negedge clk) begin
    if (!rst && bus_a.wb_en) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL wb_a_unexpected actual addr=%0d data=%h expected none", bus_a.wb_addr, bus_a.wb_data);
      end else begin
        exp_a = qa.pop_front();
        if (bus_a.wb_addr !== exp_a.addr || bus_a.wb_data !== exp_a.data) begin
          errors++;
          $display("FAIL wb_a actual addr=%0d data=%h expected addr=%0d data=%h",
                   bus_a.wb_addr, bus_a.wb_data, exp_a.addr, exp_a.data);
        end
      end
    end
  end

  wb_t exp_b;
  always @(negedge clk) begin
    if (!rst && bus_b.wb_en) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL wb_b_unexpected actual addr=%0d data=%h expected none", bus_b.wb_addr, bus_b.wb_data);
      end else begin
        exp_b = qb.pop_front();
        if (bus_b.wb_addr !== exp_b.addr || bus_b.wb_data !== exp_b.data) begin
          errors++;
          $display("FAIL wb_b actual addr=%0d data=%h expected addr=%0d data=%h",
                   bus_b.wb_addr, bus_b.wb_data, exp_b.addr, exp_b.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input int op, input int fi, input int fj, input int fk);
    bus_a.issue_op    = 4'(op);
    bus_a.issue_fi    = 5'(fi);
    bus_a.issue_fj    = 5'(fj);
    bus_a.issue_fk    = 5'(fk);
    bus_a.issue_valid = 1'b1;
    tick();
    bus_a.issue_valid = 1'b0;
  endtask

  task automatic grant_a(input logic [31:0] j, input logic [31:0] k);
    bus_a.src_j_data = j;
    bus_a.src_k_data = k;
    bus_a.read_grant = 1'b1;
    tick();
    bus_a.read_grant = 1'b0;
  endtask

  task automatic wait_wbreq_a();
    int n = 0;
    while (!bus_a.wb_req && n < 40) begin
      tick();
      n++;
    end
    chk("wb_req_a_timeout", 32'(bus_a.wb_req), 32'd1);
  endtask

  task automatic run_a(input int op, input int fi, input logic [31:0] j, input logic [31:0] k,
                       input logic [31:0] expd, input int stall);
    issue_a(op, fi, 1, 2);
    qa.push_back({5'(fi), expd});
    grant_a(j, k);
    wait_wbreq_a();
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("war_wb_req", 32'(bus_a.wb_req), 32'd1);
      chk("war_wb_en", 32'(bus_a.wb_en), 32'd0);
    end
    bus_a.wb_grant = 1'b1;
    #1;
    chk("wb_en_on_grant", 32'(bus_a.wb_en), 32'd1);
    tick();
    bus_a.wb_grant = 1'b0;
    chk("busy_after_wb", 32'(bus_a.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.issue_valid = 0; bus_a.issue_op = 0; bus_a.issue_fi = 0; bus_a.issue_fj = 0;
    bus_a.issue_fk = 0; bus_a.read_grant = 0; bus_a.src_j_data = 0; bus_a.src_k_data = 0;
    bus_a.wb_grant = 0; bus_a.flush = 0;
    bus_b.issue_valid = 0; bus_b.issue_op = 0; bus_b.issue_fi = 0; bus_b.issue_fj = 0;
    bus_b.issue_fk = 0; bus_b.read_grant = 0; bus_b.src_j_data = 0; bus_b.src_k_data = 0;
    bus_b.wb_grant = 0; bus_b.flush = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_wb_req", 32'(bus_a.wb_req), 0);
    chk("rst_wb_en", 32'(bus_a.wb_en), 0);
    chk("rst_issue_err", 32'(bus_a.issue_err), 0);
    chk("rst_dest_reg", 32'(bus_a.dest_reg), 0);
    chk("rst_rd_j", 32'(bus_a.rd_j_addr), 0);
    chk("rst_wb_data", bus_a.wb_data, 0);

    // ADD with a 10-cycle operand stall and exact latency check
    issue_a(OP_ADD, 3, 1, 2);
    chk("busy_after_issue", 32'(bus_a.busy), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_busy", 32'(bus_a.busy), 1);
      chk("stall_wb_req", 32'(bus_a.wb_req), 0);
      chk("stall_rd_j", 32'(bus_a.rd_j_addr), 1);
      chk("stall_rd_k", 32'(bus_a.rd_k_addr), 2);
    end
    qa.push_back({5'd3, 32'd12});
    grant_a(32'd5, 32'd7);
    for (int i = 0; i < 4; i++) begin
      chk("lat_wb_req_low", 32'(bus_a.wb_req), 0);
      tick();
    end
    chk("lat_wb_req_high", 32'(bus_a.wb_req), 1);
    chk("add_wb_addr", 32'(bus_a.wb_addr), 3);
    chk("add_wb_data", bus_a.wb_data, 32'd12);
    bus_a.wb_grant = 1'b1;
    #1 chk("add_wb_en", 32'(bus_a.wb_en), 1);
    tick();
    bus_a.wb_grant = 1'b0;
    chk("add_busy_low", 32'(bus_a.busy), 0);

    run_a(OP_MUL, 6, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 5);
    run_a(OP_SUB, 7, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);
    run_a(OP_SLL, 8, 32'd1, 32'h21, 32'd2, 0);
    run_a(OP_AND, 9, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);
    run_a(OP_OR, 10, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    run_a(OP_XOR, 11, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0);
    run_a(OP_SRL, 12, 32'h8000_0000, 32'h1F, 32'd1, 0);
    run_a(12, 13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0);

    // Flush in EXEC
    issue_a(OP_ADD, 14, 1, 2);
    grant_a(32'd1, 32'd1);
    tick();
    chk("exec_busy", 32'(bus_a.busy), 1);
    bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0;
    chk("flush_exec_busy", 32'(bus_a.busy), 0);
    chk("flush_exec_wb_req", 32'(bus_a.wb_req), 0);
    repeat (8) tick();
    run_a(OP_ADD, 15, 32'd100, 32'd23, 32'd123, 0);

    // Flush in WAIT_WB together with wb_grant
    issue_a(OP_ADD, 16, 1, 2);
    grant_a(32'd2, 32'd2);
    wait_wbreq_a();
    bus_a.flush = 1'b1;
    bus_a.wb_grant = 1'b1;
    #1 chk("flush_wb_en", 32'(bus_a.wb_en), 0);
    tick();
    bus_a.flush = 1'b0;
    bus_a.wb_grant = 1'b0;
    chk("flush_wb_busy", 32'(bus_a.busy), 0);
    chk("flush_wb_req", 32'(bus_a.wb_req), 0);
    repeat (3) tick();

    // Spurious issue while busy
    issue_a(OP_ADD, 4, 8, 9);
    bus_a.issue_op = 4'(OP_SUB);
    bus_a.issue_fi = 5'd7;
    bus_a.issue_valid = 1'b1;
    tick();
    bus_a.issue_valid = 1'b0;
    chk("issue_err_set", 32'(bus_a.issue_err), 1);
    chk("busy_issue_dest", 32'(bus_a.dest_reg), 4);
    chk("busy_issue_rd_j", 32'(bus_a.rd_j_addr), 8);
    qa.push_back({5'd4, 32'd30});
    grant_a(32'd10, 32'd20);
    wait_wbreq_a();
    bus_a.wb_grant = 1'b1;
    tick();
    bus_a.wb_grant = 1'b0;
    chk("issue_err_sticky", 32'(bus_a.issue_err), 1);

    // Asynchronous reset mid-EXEC
    issue_a(OP_ADD, 5, 1, 2);
    grant_a(32'd3, 32'd4);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus_a.busy), 0);
    chk("arst_wb_req", 32'(bus_a.wb_req), 0);
    chk("arst_issue_err", 32'(bus_a.issue_err), 0);
    chk("arst_dest_reg", 32'(bus_a.dest_reg), 0);
    chk("arst_rd_k", 32'(bus_a.rd_k_addr), 0);
    chk("arst_wb_addr", 32'(bus_a.wb_addr), 0);
    chk("arst_wb_data", bus_a.wb_data, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("arst_no_wb_req", 32'(bus_a.wb_req), 0);

    // LATENCY=1 unit
    bus_b.issue_op = 4'(OP_ADD); bus_b.issue_fi = 5'd5; bus_b.issue_fj = 5'd1; bus_b.issue_fk = 5'd2;
    bus_b.issue_valid = 1'b1;
    tick();
    bus_b.issue_valid = 1'b0;
    chk("l1_wb_req_before", 32'(bus_b.wb_req), 0);
    qb.push_back({5'd5, 32'd5});
    bus_b.src_j_data = 32'd2; bus_b.src_k_data = 32'd3; bus_b.read_grant = 1'b1;
    tick();
    bus_b.read_grant = 1'b0;
    chk("l1_wb_req", 32'(bus_b.wb_req), 1);
    chk("l1_wb_data", bus_b.wb_data, 32'd5);
    bus_b.wb_grant = 1'b1;
    #1 chk("l1_wb_en", 32'(bus_b.wb_en), 1);
    tick();
    bus_b.wb_grant = 1'b0;
    chk("l1_busy_low", 32'(bus_b.busy), 0);

    bus_b.issue_op = 4'(OP_MUL); bus_b.issue_fi = 5'd9;
    bus_b.issue_valid = 1'b1;
    tick();
    bus_b.issue_valid = 1'b0;
    qb.push_back({5'd9, 32'd42});
    bus_b.src_j_data = 32'd7; bus_b.src_k_data = 32'd6; bus_b.read_grant = 1'b1;
    tick();
    bus_b.read_grant = 1'b0;
    chk("l1_mul_wb_req", 32'(bus_b.wb_req), 1);
    bus_b.wb_grant = 1'b1;
    tick();
    bus_b.wb_grant = 1'b0;

    repeat (3) tick();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
